// File: rtl/l2_bank_arbiter_pkg.sv
// Shared types for the L2 bank arbiter: FSM state encoding, the TCDM request
// bundle, and the address helper used by the clear sequencer.
package l2_arb_pkg;

  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] add;
    logic        wen;
    logic [35:0] wdata;
    logic [3:0]  be;
  } tcdm_req_t;

  // Word index to byte address; the arithmetic wraps at 32 bits.
  function automatic logic [31:0] word_addr(input logic [31:0] base,
                                            input logic [31:0] idx,
                                            input logic [31:0] stride);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/l2_bank_arbiter_if.sv
// TCDM bus bundle with N request lanes and one shared response data path.
// N = NB_REQ on the requester side, N = 1 on the bank side.
interface l2_bank_arbiter_if #(
  parameter int unsigned N = 1
) ();

  logic [N-1:0]       req;
  logic [N-1:0][31:0] add;
  logic [N-1:0]       wen;
  logic [N-1:0][35:0] wdata;
  logic [N-1:0][3:0]  be;
  logic [N-1:0]       gnt;
  logic [N-1:0]       r_valid;
  logic [35:0]        r_rdata;
  logic               r_opc;

  modport master (
    output req, add, wen, wdata, be,
    input  gnt, r_valid, r_rdata, r_opc
  );

  modport slave (
    input  req, add, wen, wdata, be,
    output gnt, r_valid, r_rdata, r_opc
  );

endinterface

// File: rtl/l2_bank_arbiter_rr_arbiter.sv
// Purely combinational round-robin picker: first set request at or after ptr_i,
// wrapping modulo N. The winner index is valid whenever any request is set.
module rr_arbiter #(
  parameter int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int off);
    int s;
    s = (int'(p) + off) % int'(N);
    return IW'(s);
  endfunction

  always_comb begin
    // NOTE: defaults first on every combinational output so no path leaves one unassigned (no latch).
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    // Scan from the farthest offset down so the nearest set request overwrites.
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (req_i[wrap_idx(ptr_i, i)]) begin
        valid_o = 1'b1;
        idx_o   = wrap_idx(ptr_i, i);
      end
    end
    if (valid_o && en_i) gnt_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/l2_bank_arbiter.sv
// Round-robin sharing of one single-ported L2 bank among NB_REQ requesters,
// with response routing and a bank clear sequencer that blocks requesters.
module l2_bank_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned NB_REQ      = 4,
  parameter logic [31:0] BANK_BASE   = 32'h1C00_0000,
  parameter int unsigned BANK_WORDS  = 32768,
  parameter int unsigned ADDR_STRIDE = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  l2_bank_arbiter_if.slave  req_if,
  l2_bank_arbiter_if.master mem_if,
  input  logic              clear_i,
  output logic              clear_busy_o,
  output logic              clear_done_o
);

  localparam int unsigned IW = $clog2(NB_REQ);
  localparam int unsigned CW = $clog2(BANK_WORDS);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] resp_id_q, resp_id_d;
  logic          resp_own_q, resp_own_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [NB_REQ-1:0] win_gnt;
  logic [IW-1:0]     win_idx;
  logic              any_req;
  logic              arb_en;
  tcdm_req_t         win_req;
  tcdm_req_t         mem_fields;
  logic              mem_req;
  logic [NB_REQ-1:0] gnt;
  logic [NB_REQ-1:0] r_valid;

  assign arb_en = (state_q == ST_ARB) && mem_if.gnt[0];

  rr_arbiter #(.N(NB_REQ)) u_rr_arbiter (
    .req_i  (req_if.req),
    .ptr_i  (rr_ptr_q),
    .en_i   (arb_en),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx),
    .valid_o(any_req)
  );

  always_comb begin
    win_req.add   = req_if.add[win_idx];
    win_req.wen   = req_if.wen[win_idx];
    win_req.wdata = req_if.wdata[win_idx];
    win_req.be    = req_if.be[win_idx];
  end

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    resp_id_d    = resp_id_q;
    resp_own_d   = 1'b0;
    cnt_d        = cnt_q;
    mem_req      = 1'b0;
    mem_fields   = win_req;
    gnt          = '0;
    clear_done_o = 1'b0;

    unique case (state_q)
      ST_ARB: begin
        mem_req = any_req;
        gnt     = win_gnt;
        if (any_req && mem_if.gnt[0]) begin
          rr_ptr_d   = (win_idx == IW'(NB_REQ - 1)) ? '0 : win_idx + IW'(1);
          resp_id_d  = win_idx;
          resp_own_d = 1'b1;
        end
        if (clear_i) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        // Zero data and zero tags, full-word write; its acks stay unrouted.
        mem_req          = 1'b1;
        mem_fields.add   = word_addr(BANK_BASE, 32'(cnt_q), 32'(ADDR_STRIDE));
        mem_fields.wen   = 1'b0;
        mem_fields.wdata = '0;
        mem_fields.be    = 4'hF;
        if (mem_if.gnt[0]) begin
          if (cnt_q == CW'(BANK_WORDS - 1)) begin
            state_d      = ST_ARB;
            cnt_d        = '0;
            clear_done_o = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_comb begin
    r_valid = '0;
    if (resp_own_q) r_valid[resp_id_q] = mem_if.r_valid[0];
  end

  assign mem_if.req[0]   = mem_req;
  assign mem_if.add[0]   = mem_fields.add;
  assign mem_if.wen[0]   = mem_fields.wen;
  assign mem_if.wdata[0] = mem_fields.wdata;
  assign mem_if.be[0]    = mem_fields.be;

  assign req_if.gnt     = gnt;
  assign req_if.r_valid = r_valid;
  assign req_if.r_rdata = mem_if.r_rdata;
  assign req_if.r_opc   = mem_if.r_opc;

  assign clear_busy_o = (state_q == ST_CLEAR);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      resp_id_q  <= '0;
      resp_own_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      resp_id_q  <= resp_id_d;
      resp_own_q <= resp_own_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule

// File: tb/tb_l2_bank_arbiter.sv
// Directed bench for l2_bank_arbiter: 4 requesters, a 16-word bank with a
// 16-byte stride, and a bank model that answers one cycle after each handshake.
module tb_l2_bank_arbiter;

  localparam logic [31:0] BASE = 32'h1C00_0000;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic clear_i;
  logic clear_busy;
  logic clear_done;

  int n_checks = 0;
  int n_fail   = 0;

  l2_bank_arbiter_if #(.N(4)) req_if ();
  l2_bank_arbiter_if #(.N(1)) mem_if ();

  l2_bank_arbiter #(
    .NB_REQ     (4),
    .BANK_BASE  (BASE),
    .BANK_WORDS (16),
    .ADDR_STRIDE(16)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_if      (req_if),
    .mem_if      (mem_if),
    .clear_i     (clear_i),
    .clear_busy_o(clear_busy),
    .clear_done_o(clear_done)
  );

  always #5 clk_i = ~clk_i;

  // Bank model: fixed one-cycle response; read data is a tag of 5 over the address.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_if.r_valid <= '0;
      mem_if.r_rdata <= '0;
    end else begin
      mem_if.r_valid[0] <= mem_if.req[0] & mem_if.gnt[0];
      mem_if.r_rdata    <= {4'h5, mem_if.add[0]};
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  logic [3:0]  exp_vec;
  logic [31:0] exp_addr;
  int          rv_cnt [4];

  initial begin
    rst_ni         = 1'b0;
    clear_i        = 1'b0;
    req_if.req     = '0;
    req_if.wen     = '1;
    req_if.be      = '1;
    req_if.wdata   = '0;
    mem_if.gnt     = '0;
    mem_if.r_opc   = 1'b0;
    for (int i = 0; i < 4; i++) req_if.add[i] = BASE + 32'(32'h100 * i);
    for (int i = 0; i < 4; i++) rv_cnt[i] = 0;

    #12;
    check("rst_gnt", req_if.gnt, 4'b0000);
    check("rst_rvalid", req_if.r_valid, 4'b0000);
    check("rst_busy", clear_busy, 1'b0);
    check("rst_done", clear_done, 1'b0);
    check("rst_mem_req", mem_if.req[0], 1'b0);
    rst_ni = 1'b1;

    // All four requesters contend; expect 0,1,2,3,0,1,2,3.
    for (int k = 0; k < 8; k++) begin
      next_cycle();
      if (k == 0) begin
        req_if.req    = 4'b1111;
        mem_if.gnt[0] = 1'b1;
      end
      #4;
      exp_vec = 4'b0001 << (k % 4);
      check("rr_gnt", req_if.gnt, exp_vec);
      exp_vec = (k == 0) ? 4'b0000 : 4'b0001 << ((k - 1) % 4);
      check("rr_rvalid", req_if.r_valid, exp_vec);
      if (k > 0) begin
        exp_addr = BASE + 32'(32'h100 * ((k - 1) % 4));
        check("rr_rdata", req_if.r_rdata, {4'h5, exp_addr});
      end
      for (int b = 0; b < 4; b++) rv_cnt[b] += int'(req_if.r_valid[b]);
    end
    next_cycle();
    req_if.req = '0;
    #4;
    check("rr_last_rvalid", req_if.r_valid, 4'b1000);
    for (int b = 0; b < 4; b++) rv_cnt[b] += int'(req_if.r_valid[b]);
    for (int b = 0; b < 4; b++) check("rr_rvalid_count", 64'(rv_cnt[b]), 64'd2);

    // Bank stalls: nobody is granted and the pointer must not move.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      req_if.req    = 4'b0011;
      mem_if.gnt[0] = 1'b0;
      #4;
      check("stall_gnt", req_if.gnt, 4'b0000);
      check("stall_mem_req", mem_if.req[0], 1'b1);
      check("stall_rvalid", req_if.r_valid, 4'b0000);
    end
    next_cycle();
    mem_if.gnt[0] = 1'b1;
    #4;
    check("stall_release_gnt", req_if.gnt, 4'b0001);
    check("stall_release_add", mem_if.add[0], BASE);
    next_cycle();
    req_if.req = '0;
    #4;
    check("stall_release_rvalid", req_if.r_valid, 4'b0001);

    // Single read by requester 2, error flag passes straight through.
    next_cycle();
    req_if.req    = 4'b0100;
    req_if.add[2] = 32'h1C00_0010;
    req_if.wen[2] = 1'b1;
    mem_if.r_opc  = 1'b1;
    #4;
    check("single_gnt", req_if.gnt, 4'b0100);
    check("single_add", mem_if.add[0], 32'h1C00_0010);
    check("single_wen", mem_if.wen[0], 1'b1);
    check("single_opc", req_if.r_opc, 1'b1);
    next_cycle();
    req_if.req   = '0;
    mem_if.r_opc = 1'b0;
    #4;
    check("single_rvalid", req_if.r_valid, 4'b0100);
    check("single_rdata", req_if.r_rdata, {4'h5, 32'h1C00_0010});

    // Full clear with requesters held active; a second clear_i mid-way is ignored.
    next_cycle();
    clear_i = 1'b1;
    #4;
    check("clr_start_busy", clear_busy, 1'b0);
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      clear_i = (k == 3);
      if (k == 0) req_if.req = 4'b1111;
      #4;
      exp_addr = BASE + 32'(16 * k);
      check("clr_add", mem_if.add[0], exp_addr);
      check("clr_wen", mem_if.wen[0], 1'b0);
      check("clr_wdata", mem_if.wdata[0], 36'h0);
      check("clr_be", mem_if.be[0], 4'hF);
      check("clr_mem_req", mem_if.req[0], 1'b1);
      check("clr_gnt", req_if.gnt, 4'b0000);
      check("clr_busy", clear_busy, 1'b1);
      check("clr_done", clear_done, k == 15);
      check("clr_rvalid", req_if.r_valid, 4'b0000);
    end
    next_cycle();
    clear_i = 1'b0;
    #4;
    check("clr_after_busy", clear_busy, 1'b0);
    check("clr_after_done", clear_done, 1'b0);
    check("clr_after_gnt", req_if.gnt, 4'b1000);
    check("clr_after_rvalid", req_if.r_valid, 4'b0000);
    next_cycle();
    req_if.req = '0;
    #4;
    check("clr_after_resp", req_if.r_valid, 4'b1000);

    // Reset lands at clear word 5.
    next_cycle();
    clear_i = 1'b1;
    #4;
    for (int k = 0; k < 6; k++) begin
      next_cycle();
      clear_i = 1'b0;
      #4;
      exp_addr = BASE + 32'(16 * k);
      check("rstclr_add", mem_if.add[0], exp_addr);
      check("rstclr_done", clear_done, 1'b0);
    end
    #1;
    rst_ni = 1'b0;
    #1;
    check("rstclr_busy", clear_busy, 1'b0);
    check("rstclr_mem_req", mem_if.req[0], 1'b0);
    check("rstclr_gnt", req_if.gnt, 4'b0000);
    check("rstclr_rvalid", req_if.r_valid, 4'b0000);
    check("rstclr_done_async", clear_done, 1'b0);
    next_cycle();
    #4;
    check("rstclr_hold_busy", clear_busy, 1'b0);
    rst_ni = 1'b1;
    next_cycle();
    #4;
    check("rstclr_idle_busy", clear_busy, 1'b0);
    check("rstclr_idle_done", clear_done, 1'b0);

    // Clear starts in the same cycle as a requester 1 read handshake.
    next_cycle();
    req_if.req    = 4'b0010;
    req_if.add[1] = BASE + 32'h44;
    req_if.wen[1] = 1'b1;
    clear_i       = 1'b1;
    #4;
    check("mix_gnt", req_if.gnt, 4'b0010);
    check("mix_busy", clear_busy, 1'b0);
    for (int k = 0; k < 16; k++) begin
      next_cycle();
      if (k == 0) begin
        clear_i    = 1'b0;
        req_if.req = '0;
      end
      #4;
      exp_addr = BASE + 32'(16 * k);
      check("mix_add", mem_if.add[0], exp_addr);
      check("mix_busy_clr", clear_busy, 1'b1);
      check("mix_done", clear_done, k == 15);
      if (k == 0) begin
        check("mix_rvalid_first", req_if.r_valid, 4'b0010);
        check("mix_rdata_first", req_if.r_rdata, {4'h5, BASE + 32'h44});
      end else begin
        check("mix_rvalid", req_if.r_valid, 4'b0000);
      end
    end
    next_cycle();
    #4;
    check("mix_end_busy", clear_busy, 1'b0);
    check("mix_end_mem_req", mem_if.req[0], 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
